sn_spike_sched: RTL
===================

// Module: sn_spike_sched
// PURPOSE
//  Transmit-period scheduler between neuron array and API controller. On nc_transmit, snapshots per-neuron
//  spike flags, then serialises IDs of spiking neurons (lowest index first) onto a valid/ready stream.
//  Returns a 1-cycle done pulse, which the network controller takes as api_nc_done to end the period.
// PARAMETERS
//  P_NUM_NEURONS  100  number of neurons; ID width = $clog2(P_NUM_NEURONS)
// PORTS
//  clk            in   1      clock
//  rst_n          in   1      asynchronous reset, active low
//  nc_transmit    in   1      level; high for the whole transmit period
//  nrn_spike      in   P_NUM_NEURONS  per-neuron spike status; stable while nc_transmit is high
//  ss_api_valid   out  1      spike ID valid
//  ss_api_id      out  ID_W   neuron index of spike
//  api_ss_ready   in   1      API controller accepts ID (handshake = valid & ready)
//  ss_nc_done     out  1      1-cycle pulse: all snapshot spikes transmitted
//  ss_io_spike_cnt out $clog2(P_NUM_NEURONS+1)  spikes sent in last completed period (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async assert, sync deassert by top): state=IDLE, pending=0, valid=0, id=0, done=0, cnt=0.
//  FSM states: IDLE, SCAN, DONE, WAIT_LO (typedef in sn_pkg).
//  - IDLE: when nc_transmit=1 at edge T -> pending<=nrn_spike, run_cnt<=0, go SCAN.
//  - SCAN: output slot loads when (!valid || ready) && pending!=0: id<=lowest set bit of pending,
//    valid<=1, that bit cleared in pending in the same edge. Otherwise a handshake without reload -> valid<=0.
//    Throughput 1 ID/cycle with ready held high; first valid visible in cycle T+1 after SCAN entry (T+2 from rise).
//    ss_api_id and ss_api_valid registered; id held stable while valid && !ready.
//    Exit to DONE when pending==0 && (!valid || ready); done<=1 on that edge.
//  - DONE: ss_nc_done=1 for exactly this one cycle; go WAIT_LO.
//  - WAIT_LO: hold until nc_transmit=0, then IDLE. Prevents re-triggering on the same period.
//  Boundaries:
//  - Zero spikes: done pulse in cycle T+2, valid never asserted.
//  - All P_NUM_NEURONS spiking: IDs 0..N-1 in order, no gaps under ready=1, done the cycle after last handshake.
//  - Backpressure: ready low any number of cycles -> id/valid frozen, pending unchanged.
//  - nc_transmit falls in SCAN/DONE (abort): next edge -> IDLE, valid<=0, pending<=0, no done pulse,
//    ss_io_spike_cnt not updated.
//  - nrn_spike changes after snapshot: ignored until next period.
//  - rst_n mid-period: all state cleared immediately; no done pulse.
//  Arithmetic: run_cnt +1 per handshake, saturates at P_NUM_NEURONS (cannot exceed it by construction).
// CONFIGURATION
//  SN_SPIKE_SCHED_CNT_EN defined: run_cnt is implemented; ss_io_spike_cnt<=run_cnt (incl. final handshake)
//    on the edge entering DONE, holds until next DONE or reset.
//  Undefined: no counter logic; ss_io_spike_cnt tied to 0. Stream and done behaviour are identical.
// STRUCTURE
//  sn_pkg: sn_spike_sched_state_e enum, localparam function for ID width.
//  Sub-module sn_prio_enc #(P_WIDTH): combinational lowest-set-bit index + any-set flag.
//  Sequential logic (FSM, pending mask, output reg, counter) stays in sn_spike_sched.
// TESTING (P_NUM_NEURONS=8 unless stated)
//  1 nrn_spike=8'b1010_0101, ready=1, pulse transmit -> IDs 0,2,5,7 on consecutive cycles; done 1 cycle after 7; cnt=4.
//  2 nrn_spike=0 -> no valid; done exactly at T+2; cnt=0; WAIT_LO until transmit drops.
//  3 nrn_spike=8'hFF, ready toggled 1/0 each cycle -> IDs 0..7 in order, id stable while ready=0; cnt=8.
//  4 nrn_spike=8'h81, drop nc_transmit after first handshake -> valid falls, no done, cnt keeps previous value.
//  5 rst_n low during SCAN with ready=0 -> valid/done/cnt zero asynchronously; fresh period after release sends full set.
//  6 P_NUM_NEURONS=100, random spikes, random ready -> scoreboard: ascending unique IDs equal to set bits, one done per period.

Source files
------------

// File: rtl/sn_pkg.sv
// Shared types and helpers for the spike scheduler: FSM state encoding and ID width.
package sn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SCAN    = 2'd1,
      ST_DONE    = 2'd2,
      ST_WAIT_LO = 2'd3
   } sn_spike_sched_state_e;

   // Width of a neuron index; never below one bit so single-neuron builds still elaborate.
   function automatic int sn_id_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sn_prio_enc.sv
// Combinational priority encoder: index of the lowest set bit of i_vec plus an any-set flag.
module sn_prio_enc
   import sn_pkg::*;
#(
   parameter  int P_WIDTH = 8,
   localparam int ID_W    = sn_id_w(P_WIDTH)
) (
   input  logic [P_WIDTH-1:0] i_vec,
   output logic [ID_W-1:0]    o_idx,
   output logic               o_any
);

   // Scanning downward lets the last hit, i.e. the lowest index, win.
   always_comb begin
      o_idx = '0;
      o_any = 1'b0;
      for (int i = P_WIDTH - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_idx = ID_W'(i);
            o_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sn_spike_sched.sv
// Transmit-period spike scheduler: snapshots spike flags and streams spiking IDs lowest-first.
// Optional per-period spike counter enabled by defining SN_SPIKE_SCHED_CNT_EN.
module sn_spike_sched
   import sn_pkg::*;
#(
   parameter  int P_NUM_NEURONS = 100,
   localparam int ID_W          = sn_id_w(P_NUM_NEURONS),
   localparam int CNT_W         = $clog2(P_NUM_NEURONS + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     nc_transmit,
   input  logic [P_NUM_NEURONS-1:0] nrn_spike,
   output logic                     ss_api_valid,
   output logic [ID_W-1:0]          ss_api_id,
   input  logic                     api_ss_ready,
   output logic                     ss_nc_done,
   output logic [CNT_W-1:0]         ss_io_spike_cnt
);

   sn_spike_sched_state_e      r_state;
   logic [P_NUM_NEURONS-1:0]   r_pending;
   logic                       r_valid;
   logic [ID_W-1:0]            r_id;
   logic                       r_done;

   logic [ID_W-1:0]            w_idx;
   logic                       w_any;
   logic                       w_hs;
   logic                       w_slot_free;
   logic                       w_scan_exit;

   sn_prio_enc #(.P_WIDTH(P_NUM_NEURONS)) u_prio_enc (
      .i_vec (r_pending),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   assign w_hs        = r_valid & api_ss_ready;
   assign w_slot_free = ~r_valid | api_ss_ready;
   assign w_scan_exit = (r_state == ST_SCAN) & nc_transmit & w_slot_free & ~w_any;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_pending <= '0;
         r_valid   <= 1'b0;
         r_id      <= '0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_valid <= 1'b0;
               r_done  <= 1'b0;
               if (nc_transmit) begin
                  r_pending <= nrn_spike;
                  r_state   <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (!nc_transmit) begin
                  r_state   <= ST_IDLE;
                  r_valid   <= 1'b0;
                  r_pending <= '0;
               end else begin
                  // x & (x-1) clears exactly the bit the encoder just reported.
                  if (w_slot_free && w_any) begin
                     r_id      <= w_idx;
                     r_valid   <= 1'b1;
                     r_pending <= r_pending & (r_pending - P_NUM_NEURONS'(1));
                  end else if (w_hs) begin
                     r_valid <= 1'b0;
                  end
                  if (w_scan_exit) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_state <= nc_transmit ? ST_WAIT_LO : ST_IDLE;
            end
            ST_WAIT_LO: begin
               if (!nc_transmit) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign ss_api_valid = r_valid;
   assign ss_api_id    = r_id;
   assign ss_nc_done   = r_done;

`ifdef SN_SPIKE_SCHED_CNT_EN
   logic [CNT_W-1:0] r_run_cnt;
   logic [CNT_W-1:0] r_spike_cnt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v >= CNT_W'(P_NUM_NEURONS)) ? v : v + CNT_W'(1);
   endfunction

   // Published count includes the handshake that coincides with the exit edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run_cnt   <= '0;
         r_spike_cnt <= '0;
      end else begin
         if (r_state == ST_IDLE && nc_transmit) begin
            r_run_cnt <= '0;
         end else if (r_state == ST_SCAN && nc_transmit) begin
            if (w_hs) begin
               r_run_cnt <= sat_inc(r_run_cnt);
            end
            if (w_scan_exit) begin
               r_spike_cnt <= w_hs ? sat_inc(r_run_cnt) : r_run_cnt;
            end
         end
      end
   end

   assign ss_io_spike_cnt = r_spike_cnt;
`else
   assign ss_io_spike_cnt = '0;
`endif

endmodule
